glb_bank_arbiter: RTL and testbench

Shares one global-buffer bank memory among NUM_PORTS requesters: processor, streaming and config-path ports. It grants at most one access per cycle (round-robin with a configurable burst hold, or fixed priority) and drives the bank memory's ren/wen/addr/data/bit-select inputs. It tracks every issued read through a RD_LATENCY-deep tag pipeline and returns each read to the port that issued it. It sits between the tile's request crossbar and the bank memory instance.

---
 rtl/global_buffer_param.sv | 10 +
 rtl/global_buffer_pkg.sv | 18 +
 rtl/glb_rr_picker.sv | 43 ++++
 rtl/glb_bank_arbiter.sv | 157 +++++++++++++++
 tb/tb_glb_bank_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/global_buffer_param.sv
// rtl/global_buffer_param.sv - global buffer bank geometry shared by bank-side blocks
//
// Purpose: byte-address and data widths of one global-buffer bank.
// Ports: none (package).
package global_buffer_param;

  localparam int BANK_ADDR_WIDTH = 17;
  localparam int BANK_DATA_WIDTH = 64;

endpackage

// File: rtl/global_buffer_pkg.sv
// rtl/global_buffer_pkg.sv - shared types and constants for global buffer bank blocks
//
// Purpose: read latency shared by the bank memory and its arbiter, and the
// read-tag type that travels alongside an in-flight bank read.
// Ports: none (package).
package global_buffer_pkg;

  // Must match the output pipeline depth of the bank memory instance.
  localparam int GLB_BANK_RD_LATENCY = 3;
  localparam int GLB_BANK_NUM_PORTS  = 3;
  localparam int GLB_BANK_PORT_W     = $clog2(GLB_BANK_NUM_PORTS);

  typedef struct packed {
    logic                       valid;
    logic [GLB_BANK_PORT_W-1:0] port;
  } glb_bank_tag_t;

endpackage

// File: rtl/glb_rr_picker.sv
// rtl/glb_rr_picker.sv - combinational round-robin first-one finder
//
// Purpose: returns the first set bit of req searching start, start+1, ...
// with wrap-around.
// Ports:
//   req    in   N      request vector
//   start  in   IDX_W  first index searched (must be < N)
//   grant  out  N      one-hot of the found index, 0 when nothing requests
//   idx    out  IDX_W  found index, 0 when nothing requests
//   found  out  1      any request present
module glb_rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      // start + k < 2N, so a single conditional subtract is enough to wrap.
      sum  = {1'b0, start} + (IDX_W+1)'(k);
      cand = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N)) : sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glb_bank_arbiter.sv
// rtl/glb_bank_arbiter.sv - single-port global buffer bank arbiter with read return routing
//
// Purpose: grants at most one requester per cycle onto the bank memory port
// (fixed priority or round-robin with burst hold) and routes each read's data
// back to its issuer RD_LATENCY cycles later.
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   cfg_fixed_prio, cfg_max_burst      arbitration mode and round-robin burst length
//   req_rd_en/wr_en/addr/data/bit_sel  per-port request fields
//   req_ready                          one-hot combinational grant
//   rd_data, rd_data_valid             read return data and one-hot owner
//   mem_ren/wen/addr/data_in/bit_sel   bank memory request side
//   mem_data_out                       bank memory read data
module glb_bank_arbiter
  import global_buffer_param::*;
  import global_buffer_pkg::*;
#(
  parameter int NUM_PORTS  = GLB_BANK_NUM_PORTS,
  parameter int RD_LATENCY = GLB_BANK_RD_LATENCY,
  parameter int BURST_W    = 4
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic                                         cfg_fixed_prio,
  input  logic [BURST_W-1:0]                           cfg_max_burst,
  input  logic [NUM_PORTS-1:0]                         req_rd_en,
  input  logic [NUM_PORTS-1:0]                         req_wr_en,
  input  logic [NUM_PORTS-1:0][BANK_ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_PORTS-1:0][BANK_DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_PORTS-1:0][BANK_DATA_WIDTH-1:0]    req_bit_sel,
  output logic [NUM_PORTS-1:0]                         req_ready,
  output logic [BANK_DATA_WIDTH-1:0]                   rd_data,
  output logic [NUM_PORTS-1:0]                         rd_data_valid,
  output logic                                         mem_ren,
  output logic                                         mem_wen,
  output logic [BANK_ADDR_WIDTH-1:0]                   mem_addr,
  output logic [BANK_DATA_WIDTH-1:0]                   mem_data_in,
  output logic [BANK_DATA_WIDTH-1:0]                   mem_data_in_bit_sel,
  input  logic [BANK_DATA_WIDTH-1:0]                   mem_data_out
);

  localparam int IDX_W = GLB_BANK_PORT_W;

  logic [NUM_PORTS-1:0] req_any;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [BURST_W:0]     max_burst;
  logic [BURST_W:0]     burst_next;
  logic                 hold;
  logic [IDX_W-1:0]     pick_start;
  logic [NUM_PORTS-1:0] pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [IDX_W-1:0]     grant_idx;
  logic                 grant_vld;

  glb_bank_tag_t tag_q [RD_LATENCY];
  glb_bank_tag_t tag_d [RD_LATENCY];
  glb_bank_tag_t last_tag;

  assign req_any = req_rd_en | req_wr_en;

  // A zero burst setting behaves like one grant per turn.
  assign max_burst  = (cfg_max_burst == '0) ? (BURST_W+1)'(1) : {1'b0, cfg_max_burst};
  assign burst_next = {1'b0, burst_cnt_q} + 1'b1;
  assign hold       = !cfg_fixed_prio && req_any[owner_q] && (burst_next < max_burst);

  // Fixed mode searches from port 0; round-robin searches from owner+1 and
  // reaches the owner itself last.
  assign pick_start = cfg_fixed_prio ? '0 :
                      (owner_q == IDX_W'(NUM_PORTS-1)) ? '0 : owner_q + 1'b1;

  glb_rr_picker #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (req_any),
    .start (pick_start),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign grant_vld = pick_found;
  assign grant_idx = hold ? owner_q : pick_idx;
  assign req_ready = hold ? (NUM_PORTS'(1) << owner_q) : pick_grant;

  // A port raising both strobes gets a write; its read is dropped.
  always_comb begin
    mem_ren             = 1'b0;
    mem_wen             = 1'b0;
    mem_addr            = '0;
    mem_data_in         = '0;
    mem_data_in_bit_sel = '0;
    if (grant_vld) begin
      mem_wen             = req_wr_en[grant_idx];
      mem_ren             = req_rd_en[grant_idx] && !req_wr_en[grant_idx];
      mem_addr            = req_addr[grant_idx];
      mem_data_in         = req_data[grant_idx];
      mem_data_in_bit_sel = req_bit_sel[grant_idx];
    end
  end

  // Round-robin state; frozen while in fixed-priority mode.
  always_comb begin
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (!cfg_fixed_prio) begin
      if (!grant_vld) begin
        burst_cnt_d = '0;
      end else if (hold) begin
        burst_cnt_d = burst_next[BURST_W-1:0];
      end else begin
        owner_d     = pick_idx;
        burst_cnt_d = '0;
      end
    end
  end

  always_comb begin
    tag_d[0].valid = mem_ren;
    tag_d[0].port  = grant_idx;
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q     <= IDX_W'(NUM_PORTS-1);
      burst_cnt_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      tag_q       <= tag_d;
    end
  end

  assign last_tag = tag_q[RD_LATENCY-1];

  always_comb begin
    rd_data_valid = '0;
    if (last_tag.valid) begin
      rd_data_valid[last_tag.port] = 1'b1;
    end
  end

  assign rd_data = last_tag.valid ? mem_data_out : '0;

  rd_wr_both_a: assert property (@(posedge clk) disable iff (!reset_n)
    ((req_rd_en & req_wr_en & req_ready) == '0))
    else $warning("glb_bank_arbiter: port %0d raised read and write together, read dropped", grant_idx);

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// tb/tb_glb_bank_arbiter.sv - self-checking bench for glb_bank_arbiter
module tb_glb_bank_arbiter;
  import global_buffer_param::*;

  localparam int N   = 3;
  localparam int LAT = 3;
  localparam int AW  = BANK_ADDR_WIDTH;
  localparam int DW  = BANK_DATA_WIDTH;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   cfg_fixed_prio;
  logic [3:0]             cfg_max_burst;
  logic [N-1:0]           req_rd_en, req_wr_en;
  logic [N-1:0][AW-1:0]   req_addr;
  logic [N-1:0][DW-1:0]   req_data, req_bit_sel;
  logic [N-1:0]           req_ready;
  logic [DW-1:0]          rd_data;
  logic [N-1:0]           rd_data_valid;
  logic                   mem_ren, mem_wen;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_data_in, mem_data_in_bit_sel, mem_data_out;

  glb_bank_arbiter #(.NUM_PORTS(N), .RD_LATENCY(LAT), .BURST_W(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .cfg_fixed_prio      (cfg_fixed_prio),
    .cfg_max_burst       (cfg_max_burst),
    .req_rd_en           (req_rd_en),
    .req_wr_en           (req_wr_en),
    .req_addr            (req_addr),
    .req_data            (req_data),
    .req_bit_sel         (req_bit_sel),
    .req_ready           (req_ready),
    .rd_data             (rd_data),
    .rd_data_valid       (rd_data_valid),
    .mem_ren             (mem_ren),
    .mem_wen             (mem_wen),
    .mem_addr            (mem_addr),
    .mem_data_in         (mem_data_in),
    .mem_data_in_bit_sel (mem_data_in_bit_sel),
    .mem_data_out        (mem_data_out)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 'h40) return 64'hDEAD_BEEF_0123_4567;
    if (a == 'h80) return 64'h0123_4567_89AB_CDEF;
    return {32'hC0DE_0000 | 32'(a), ~32'(a)};
  endfunction

  // Bank memory stand-in: 256 words, LAT-cycle read pipeline.
  logic [DW-1:0] env_mem [256];
  bit            env_wr  [256];
  logic [DW-1:0] env_pipe [LAT];

  function automatic logic [DW-1:0] env_rd(input int a);
    return env_wr[a] ? env_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    if (mem_wen) begin
      env_mem[int'(mem_addr[7:0])] <= (env_rd(int'(mem_addr[7:0])) & ~mem_data_in_bit_sel)
                                    | (mem_data_in & mem_data_in_bit_sel);
      env_wr[int'(mem_addr[7:0])]  <= 1'b1;
    end
    env_pipe[0] <= mem_ren ? env_rd(int'(mem_addr[7:0])) : '0;
    for (int i = 1; i < LAT; i++) env_pipe[i] <= env_pipe[i-1];
  end
  assign mem_data_out = env_pipe[LAT-1];

  // Reference model state.
  typedef struct { int due; int port; logic [DW-1:0] data; } ret_t;
  ret_t          rq[$];
  logic [DW-1:0] model_mem [256];
  bit            model_wr  [256];
  int            m_owner, m_cnt, cyc;
  int            n_cmp = 0, n_err = 0;

  bit            e_any, e_hold, e_ren, e_wen;
  int            e_idx;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data, e_bs;

  logic [N-1:0]  c_ready, c_valid;
  logic [DW-1:0] c_rd_data;
  logic          c_ren, c_wen;
  logic [AW-1:0] c_addr;

  function automatic logic [DW-1:0] model_rd(input int a);
    return model_wr[a] ? model_mem[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0]  rq_v, e_ready, e_valid;
    logic [DW-1:0] e_rdata;
    int            maxb, start, p;
    @(negedge clk);
    if (!reset_n) begin
      m_owner = N - 1;
      m_cnt   = 0;
      rq.delete();
    end
    rq_v   = req_rd_en | req_wr_en;
    e_any  = (rq_v != '0);
    e_hold = 1'b0;
    e_idx  = 0;
    maxb   = (cfg_max_burst == 0) ? 1 : int'(cfg_max_burst);
    if (e_any) begin
      if (!cfg_fixed_prio && rq_v[m_owner] && (m_cnt + 1 < maxb)) begin
        e_hold = 1'b1;
        e_idx  = m_owner;
      end else begin
        start = cfg_fixed_prio ? 0 : (m_owner + 1) % N;
        for (int k = N - 1; k >= 0; k--) begin
          p = (start + k) % N;
          if (rq_v[p]) e_idx = p;
        end
      end
    end
    e_ready = e_any ? (N'(1) << e_idx) : '0;
    e_wen   = e_any && req_wr_en[e_idx];
    e_ren   = e_any && req_rd_en[e_idx] && !req_wr_en[e_idx];
    e_addr  = e_any ? req_addr[e_idx]    : '0;
    e_data  = e_any ? req_data[e_idx]    : '0;
    e_bs    = e_any ? req_bit_sel[e_idx] : '0;
    e_valid = '0;
    e_rdata = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e_valid = N'(1) << rq[0].port;
      e_rdata = rq[0].data;
    end
    c_ready = req_ready;  c_valid = rd_data_valid;  c_rd_data = rd_data;
    c_ren   = mem_ren;    c_wen   = mem_wen;        c_addr    = mem_addr;
    chk("req_ready",     64'(req_ready),           64'(e_ready));
    chk("mem_ren",       64'(mem_ren),             64'(e_ren));
    chk("mem_wen",       64'(mem_wen),             64'(e_wen));
    chk("mem_addr",      64'(mem_addr),            64'(e_addr));
    chk("mem_data_in",   mem_data_in,              e_data);
    chk("mem_bit_sel",   mem_data_in_bit_sel,      e_bs);
    chk("rd_data_valid", 64'(rd_data_valid),       64'(e_valid));
    chk("rd_data",       rd_data,                  e_rdata);
    @(posedge clk);
    if (reset_n) begin
      if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
      if (e_ren) rq.push_back('{cyc + LAT, e_idx, model_rd(int'(e_addr[7:0]))});
      if (e_wen) begin
        model_mem[int'(e_addr[7:0])] = (model_rd(int'(e_addr[7:0])) & ~e_bs) | (e_data & e_bs);
        model_wr[int'(e_addr[7:0])]  = 1'b1;
      end
      if (!cfg_fixed_prio) begin
        if (!e_any)      m_cnt = 0;
        else if (e_hold) m_cnt = m_cnt + 1;
        else begin
          m_owner = e_idx;
          m_cnt   = 0;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic clear_reqs();
    req_rd_en = '0; req_wr_en = '0; req_addr = '0; req_data = '0; req_bit_sel = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_reqs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  logic [N-1:0] d2_g [7] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
  logic [N-1:0] d2_v [7] = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b010};

  initial begin
    reset_n = 1'b0; cfg_fixed_prio = 1'b0; cfg_max_burst = 4'd2;
    clear_reqs();
    cyc = 0; m_owner = N - 1; m_cnt = 0;

    // Reset then idle, then a read launched as reset releases.
    step(); step();
    chk("d1_idle_ready", 64'(c_ready), 64'd0);
    chk("d1_idle_valid", 64'(c_valid), 64'd0);
    chk("d1_idle_data",  c_rd_data,    64'd0);
    chk("d1_idle_wen",   64'(c_wen),   64'd0);
    chk("d1_idle_addr",  64'(c_addr),  64'd0);
    reset_n = 1'b1;
    req_rd_en = 3'b010; req_addr[1] = AW'('h40);
    step();
    chk("d1_ready", 64'(c_ready), 64'b010);
    chk("d1_ren",   64'(c_ren),   64'd1);
    clear_reqs();
    step(); step(); step();
    chk("d1_valid", 64'(c_valid), 64'b010);
    chk("d1_data",  c_rd_data,    64'hDEAD_BEEF_0123_4567);

    // Round-robin with burst 2, all ports reading.
    do_reset();
    cfg_fixed_prio = 1'b0; cfg_max_burst = 4'd2;
    req_wr_en = 3'b100; req_addr[2] = AW'('h10); req_data[2] = 64'h1; req_bit_sel[2] = '1;
    step();
    chk("d2_first", 64'(c_ready), 64'b100);
    req_wr_en = '0; req_rd_en = 3'b111;
    req_addr[0] = AW'('h20); req_addr[1] = AW'('h21); req_addr[2] = AW'('h22);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("d2_grant", 64'(c_ready), 64'(d2_g[i]));
      chk("d2_ret",   64'(c_valid), 64'(d2_v[i]));
    end
    clear_reqs();
    step(); step(); step();

    // Fixed priority starves port 2; round-robin (burst 0 == 1) reaches it.
    do_reset();
    cfg_fixed_prio = 1'b1;
    req_rd_en = 3'b110; req_addr[1] = AW'('h31); req_addr[2] = AW'('h32);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("d3_fixed", 64'(c_ready), 64'b010);
    end
    cfg_fixed_prio = 1'b0; cfg_max_burst = 4'd0;
    step();
    chk("d3_rr0", 64'(c_ready), 64'b010);
    step();
    chk("d3_rr1", 64'(c_ready), 64'b100);
    clear_reqs();
    step(); step(); step();

    // Partial write then read-after-write from another port.
    do_reset();
    cfg_fixed_prio = 1'b1;
    req_wr_en = 3'b001; req_addr[0] = AW'('h80);
    req_data[0] = 64'hA5A5_A5A5_A5A5_A5A5; req_bit_sel[0] = 64'hFFFF_FFFF_0000_0000;
    step();
    clear_reqs();
    req_rd_en = 3'b010; req_addr[1] = AW'('h80);
    step();
    chk("d4_rd_ready", 64'(c_ready), 64'b010);
    clear_reqs();
    step(); step(); step();
    chk("d4_valid", 64'(c_valid), 64'b010);
    chk("d4_data",  c_rd_data,    64'hA5A5_A5A5_89AB_CDEF);

    // Read and write together: the write goes out, no response follows.
    req_rd_en = 3'b100; req_wr_en = 3'b100; req_addr[2] = AW'('h30);
    req_data[2] = 64'h7777_0000_7777_0000; req_bit_sel[2] = '1;
    step();
    chk("d5_ready", 64'(c_ready), 64'b100);
    chk("d5_wen",   64'(c_wen),   64'd1);
    chk("d5_ren",   64'(c_ren),   64'd0);
    clear_reqs();
    step(); step(); step();
    chk("d5_noret", 64'(c_valid), 64'd0);

    // Reset with three reads in flight.
    do_reset();
    cfg_fixed_prio = 1'b0; cfg_max_burst = 4'd1;
    for (int p = 0; p < N; p++) begin
      clear_reqs();
      req_rd_en[p] = 1'b1; req_addr[p] = AW'('h50 + p);
      step();
    end
    reset_n = 1'b0;
    clear_reqs();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("d6_in_reset", 64'(c_valid), 64'd0);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("d6_after_reset", 64'(c_valid), 64'd0);
    end

    // Randomized traffic; requests hold until granted.
    do_reset();
    cfg_fixed_prio = 1'b0; cfg_max_burst = 4'd3;
    for (int c = 0; c < 2000; c++) begin
      step();
      if (e_any) begin
        req_rd_en[e_idx] = 1'b0;
        req_wr_en[e_idx] = 1'b0;
      end
      for (int p = 0; p < N; p++) begin
        if (!(req_rd_en[p] || req_wr_en[p]) && $urandom_range(0, 99) < 55) begin
          if ($urandom_range(0, 1) == 1) req_rd_en[p] = 1'b1;
          else                           req_wr_en[p] = 1'b1;
          req_addr[p]    = AW'($urandom_range(0, 15));
          req_data[p]    = {$urandom, $urandom};
          req_bit_sel[p] = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
        end
      end
      if ($urandom_range(0, 99) < 2) begin
        cfg_fixed_prio = ($urandom_range(0, 3) == 0);
        cfg_max_burst  = 4'($urandom_range(0, 15));
      end
    end
    clear_reqs();
    step(); step(); step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
